// File: rtl/riscv_defs_pkg.sv
// Shared RV32I decode constants: opcodes, one-hot EXTOp codes and the
// control-bit bundle carried from ID into EX.
package riscv_defs;

    localparam int EXTOP_W = 6;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [EXTOP_W-1:0] EXT_ITYPE_SHAMT = 6'b100000;
    localparam logic [EXTOP_W-1:0] EXT_ITYPE       = 6'b010000;
    localparam logic [EXTOP_W-1:0] EXT_STYPE       = 6'b001000;
    localparam logic [EXTOP_W-1:0] EXT_BTYPE       = 6'b000100;
    localparam logic [EXTOP_W-1:0] EXT_UTYPE       = 6'b000010;
    localparam logic [EXTOP_W-1:0] EXT_JTYPE       = 6'b000001;
    localparam logic [EXTOP_W-1:0] EXT_NONE        = 6'b000000;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic branch;
        logic jump;
    } ctrl_t;

endpackage

// File: rtl/id_stage_ctrl_decode.sv
// Pure combinational instruction classifier: opcode/funct3 to EXTOp,
// control bits, source-register usage and an illegal-opcode flag.
module id_decode
    import riscv_defs::*;
(
    input  logic [6:0]         opcode_i,
    input  logic [2:0]         funct3_i,
    output logic [EXTOP_W-1:0] extop_o,
    output ctrl_t              ctrl_o,
    output logic               rs1_used_o,
    output logic               rs2_used_o,
    output logic               illegal_o
);

    always_comb begin
        extop_o    = EXT_NONE;
        ctrl_o     = '0;
        rs1_used_o = 1'b0;
        rs2_used_o = 1'b0;
        illegal_o  = 1'b0;
        case (opcode_i)
            OPC_OP_IMM: begin
                // Shifts carry a 5-bit shamt instead of a full 12-bit immediate
                extop_o         = (funct3_i == 3'b001 || funct3_i == 3'b101) ?
                                  EXT_ITYPE_SHAMT : EXT_ITYPE;
                ctrl_o.regwrite = 1'b1;
                rs1_used_o      = 1'b1;
            end
            OPC_LOAD: begin
                extop_o         = EXT_ITYPE;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memread  = 1'b1;
                rs1_used_o      = 1'b1;
            end
            OPC_JALR: begin
                extop_o         = EXT_ITYPE;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.jump     = 1'b1;
                rs1_used_o      = 1'b1;
            end
            OPC_STORE: begin
                extop_o         = EXT_STYPE;
                ctrl_o.memwrite = 1'b1;
                rs1_used_o      = 1'b1;
                rs2_used_o      = 1'b1;
            end
            OPC_BRANCH: begin
                extop_o       = EXT_BTYPE;
                ctrl_o.branch = 1'b1;
                rs1_used_o    = 1'b1;
                rs2_used_o    = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                extop_o         = EXT_UTYPE;
                ctrl_o.regwrite = 1'b1;
            end
            OPC_JAL: begin
                extop_o         = EXT_JTYPE;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.jump     = 1'b1;
            end
            OPC_OP: begin
                ctrl_o.regwrite = 1'b1;
                rs1_used_o      = 1'b1;
                rs2_used_o      = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: load-use hazard stall, ID/EX control/immediate
// register with bubble insertion, and a saturating stall-cycle counter.
module id_stage_ctrl
    import riscv_defs::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid_i,
    input  logic [31:0]        instr_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic               illegal_o,
    output logic               ex_valid_o,
    output logic [EXTOP_W-1:0] ex_extop_o,
    output logic [4:0]         ex_shamt_o,
    output logic [11:0]        ex_iimm_o,
    output logic [11:0]        ex_simm_o,
    output logic [11:0]        ex_bimm_o,
    output logic [19:0]        ex_uimm_o,
    output logic [19:0]        ex_jimm_o,
    output logic [4:0]         ex_rs1_o,
    output logic [4:0]         ex_rs2_o,
    output logic [4:0]         ex_rd_o,
    output logic               ex_regwrite_o,
    output logic               ex_memread_o,
    output logic               ex_memwrite_o,
    output logic               ex_branch_o,
    output logic               ex_jump_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    typedef struct packed {
        logic               valid;
        logic [EXTOP_W-1:0] extop;
        logic [4:0]         shamt;
        logic [11:0]        iimm;
        logic [11:0]        simm;
        logic [11:0]        bimm;
        logic [19:0]        uimm;
        logic [19:0]        jimm;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        ctrl_t              ctrl;
    } idex_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    idex_t              idex_d, idex_q;
    logic               illegal_d, illegal_q;
    logic [CNT_W-1:0]   stall_cnt_d, stall_cnt_q;

    logic [EXTOP_W-1:0] dec_extop;
    ctrl_t              dec_ctrl;
    logic               dec_rs1_used, dec_rs2_used, dec_illegal;
    logic               load_in_ex, hazard;

    id_decode u_decode (
        .opcode_i   (instr_i[6:0]),
        .funct3_i   (instr_i[14:12]),
        .extop_o    (dec_extop),
        .ctrl_o     (dec_ctrl),
        .rs1_used_o (dec_rs1_used),
        .rs2_used_o (dec_rs2_used),
        .illegal_o  (dec_illegal)
    );

    // A load writing x0 never produces a value anyone must wait for
    assign load_in_ex = idex_q.valid && idex_q.ctrl.memread && (idex_q.rd != 5'd0);
    assign hazard     = instr_valid_i && load_in_ex &&
                        ((dec_rs1_used && (instr_i[19:15] == idex_q.rd)) ||
                         (dec_rs2_used && (instr_i[24:20] == idex_q.rd)));
    assign stall_o    = hazard && !flush_i;

    always_comb begin
        idex_d      = '0;
        illegal_d   = 1'b0;
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
            idex_d = '0;
        end else if (stall_o) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else if (instr_valid_i && dec_illegal) begin
            illegal_d = 1'b1;
        end else if (instr_valid_i) begin
            idex_d.valid = 1'b1;
            idex_d.extop = dec_extop;
            idex_d.ctrl  = dec_ctrl;
            idex_d.shamt = instr_i[24:20];
            idex_d.iimm  = instr_i[31:20];
            idex_d.simm  = {instr_i[31:25], instr_i[11:7]};
            idex_d.bimm  = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]};
            idex_d.uimm  = instr_i[31:12];
            idex_d.jimm  = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21]};
            idex_d.rs1   = instr_i[19:15];
            idex_d.rs2   = instr_i[24:20];
            idex_d.rd    = instr_i[11:7];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q      <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign illegal_o     = illegal_q;
    assign ex_valid_o    = idex_q.valid;
    assign ex_extop_o    = idex_q.extop;
    assign ex_shamt_o    = idex_q.shamt;
    assign ex_iimm_o     = idex_q.iimm;
    assign ex_simm_o     = idex_q.simm;
    assign ex_bimm_o     = idex_q.bimm;
    assign ex_uimm_o     = idex_q.uimm;
    assign ex_jimm_o     = idex_q.jimm;
    assign ex_rs1_o      = idex_q.rs1;
    assign ex_rs2_o      = idex_q.rs2;
    assign ex_rd_o       = idex_q.rd;
    assign ex_regwrite_o = idex_q.ctrl.regwrite;
    assign ex_memread_o  = idex_q.ctrl.memread;
    assign ex_memwrite_o = idex_q.ctrl.memwrite;
    assign ex_branch_o   = idex_q.ctrl.branch;
    assign ex_jump_o     = idex_q.ctrl.jump;
    assign stall_cnt_o   = stall_cnt_q;

endmodule
